// File: rtl/dcache_controller.sv
// ---------------------------------------------------------------------------
// dcache_controller
//
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// A hit completes in the access cycle. A miss raises cpu_stall_o in the same
// cycle. The FSM then writes the victim line back if it is dirty, refills the
// line from backing memory, and returns to IDLE. In IDLE the held request
// hits and completes.
//
// Optional feature: define DCACHE_STATS_EN to build saturating 32-bit
// hit/miss counters. Without it, hit_cnt_o and miss_cnt_o are tied to zero.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-low
//   cpu_req_i    MEM-stage access valid
//   cpu_we_i     1 = store word, 0 = load word
//   cpu_addr_i   byte address: [3:2] word, [3+IDX_W:4] index, rest tag
//   cpu_wdata_i  store data
//   cpu_rdata_o  load data (indexed word, meaningful on a load hit)
//   cpu_stall_o  pipeline freeze
//   mem_req_o    backing-memory request
//   mem_we_o     1 = line write-back, 0 = line fetch
//   mem_addr_o   line-aligned address
//   mem_wdata_o  evicted line, word 0 in [31:0]
//   mem_rdata_i  refill line, sampled on mem_ack_i
//   mem_ack_i    one-cycle completion pulse
//   hit_cnt_o    hit counter  (DCACHE_STATS_EN)
//   miss_cnt_o   miss counter (DCACHE_STATS_EN)
// ---------------------------------------------------------------------------
module dcache_controller #(
  parameter int LINES  = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - 4 - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  // Control state
  state_e           state_q,    state_d;
  logic             mem_req_q,  mem_req_d;
  logic             mem_we_q,   mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
  logic [LINES-1:0] valid_q,    valid_d;
  logic [LINES-1:0] dirty_q,    dirty_d;

  // Storage arrays
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  // Single write port into the storage arrays
  logic              line_we;
  logic              tag_we;
  logic [IDX_W-1:0]  line_idx;
  logic [LINE_W-1:0] line_wdata;
  logic [LINE_W-1:0] merged_line;

  // Address decode
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_off;
  logic             hit;
  logic             in_idle;
  logic             unused_addr_bits;

  assign req_off          = cpu_addr_i[3:2];
  assign req_idx          = cpu_addr_i[3+IDX_W:4];
  assign req_tag          = cpu_addr_i[31:4+IDX_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign in_idle = (state_q == IDLE);

  // A miss stalls in the cycle it is detected, before the FSM leaves IDLE.
  assign cpu_stall_o = !in_idle || (cpu_req_i && !hit);
  assign cpu_rdata_o = data_q[req_idx][{req_off, 5'b0} +: 32];
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  // The victim line is not rewritten during WRITEBACK, so it stays stable.
  assign mem_wdata_o = data_q[miss_idx_q];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    miss_idx_d  = miss_idx_q;
    miss_tag_d  = miss_tag_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    line_we     = 1'b0;
    tag_we      = 1'b0;
    line_idx    = req_idx;
    merged_line = data_q[req_idx];
    merged_line[{req_off, 5'b0} +: 32] = cpu_wdata_i;
    line_wdata  = merged_line;

    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          if (hit) begin
            if (cpu_we_i) begin
              line_we          = 1'b1;
              dirty_d[req_idx] = 1'b1;
            end
          end else begin
            // Capture the missing line's tag and index. The request itself
            // is re-read when the FSM returns to IDLE.
            miss_idx_d = req_idx;
            miss_tag_d = req_tag;
            mem_req_d  = 1'b1;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_d    = WRITEBACK;
              mem_we_d   = 1'b1;
              mem_addr_d = {tag_q[req_idx], req_idx, 4'b0};
            end else begin
              state_d    = ALLOCATE;
              mem_we_d   = 1'b0;
              mem_addr_d = {req_tag, req_idx, 4'b0};
            end
          end
        end
      end

      WRITEBACK: begin
        // The request stays asserted and switches straight to the fetch.
        if (mem_ack_i) begin
          state_d    = ALLOCATE;
          mem_we_d   = 1'b0;
          mem_addr_d = {miss_tag_q, miss_idx_q, 4'b0};
        end
      end

      ALLOCATE: begin
        // The line is installed even if cpu_req_i was dropped (flush).
        if (mem_ack_i) begin
          state_d             = IDLE;
          mem_req_d           = 1'b0;
          line_we             = 1'b1;
          tag_we              = 1'b1;
          line_idx            = miss_idx_q;
          line_wdata          = mem_rdata_i;
          valid_d[miss_idx_q] = 1'b1;
          dirty_d[miss_idx_q] = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge value regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
    end
  end

  // NOTE: the tag/data arrays are deliberately not reset. The cleared valid
  // bits already make their contents unobservable, and leaving out the reset
  // lets the arrays map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (line_we) data_q[line_idx] <= line_wdata;
    if (tag_we)  tag_q[line_idx]  <= miss_tag_q;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q,  hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        hit_access;
  logic        miss_access;

  // The completion cycle after a refill is an IDLE hit and is counted as one.
  assign hit_access  = in_idle && cpu_req_i && hit;
  assign miss_access = in_idle && cpu_req_i && !hit;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_access  && (hit_cnt_q  != '1)) hit_cnt_d  = hit_cnt_q  + 32'd1;
    if (miss_access && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = 32'd0;
  assign miss_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// ---------------------------------------------------------------------------
// tb_dcache_controller
//
// Directed scenarios followed by randomized loads and stores against a
// behavioural cache/backing-memory model. The model is kept as per-line
// arrays plus an associative array that stands in for backing memory.
// Inputs are driven at the falling edge. Outputs are sampled 1 time unit
// later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_dcache_controller;

`ifdef DCACHE_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [127:0] mem_rdata_i;
  logic         mem_ack_i;
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;

  always #5 clk = ~clk;

  dcache_controller #(.LINES(16), .LINE_W(128)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: cache contents, backing memory and expected counters
  logic         m_valid [16];
  logic         m_dirty [16];
  logic [23:0]  m_tag   [16];
  logic [127:0] m_data  [16];
  logic [127:0] bmem [logic [27:0]];
  logic [31:0]  exp_hits;
  logic [31:0]  exp_misses;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    if (!bmem.exists(la)) bmem[la] = rand_line();
    return bmem[la];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_hits   = 32'd0;
    exp_misses = 32'd0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_hit_cnt"},  hit_cnt_o,  STATS_EN ? exp_hits   : 32'd0);
    check({tag, "_miss_cnt"}, miss_cnt_o, STATS_EN ? exp_misses : 32'd0);
  endtask

  // Cycle with no CPU request. A stray ack must be ignored while mem_req_o is 0.
  task automatic idle_cycle(input logic ack);
    @(negedge clk);
    cpu_req_i   = 1'b0;
    mem_ack_i   = ack;
    mem_rdata_i = rand_line();
    #1;
    check("idle_stall",   cpu_stall_o, 1'b0);
    check("idle_mem_req", mem_req_o,   1'b0);
    @(posedge clk);
  endtask

  // Access that the model predicts to hit
  task automatic hit_cycle(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic [3:0] idx;
    logic [1:0] off;
    idx = addr[7:4];
    off = addr[3:2];
    @(negedge clk);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    mem_ack_i   = 1'($urandom_range(0, 1));
    #1;
    check("hit_stall",   cpu_stall_o, 1'b0);
    check("hit_mem_req", mem_req_o,   1'b0);
    if (!we) check("hit_rdata", cpu_rdata_o, m_data[idx][off*32 +: 32]);
    @(posedge clk);
    if (we) begin
      m_data[idx][off*32 +: 32] = wdata;
      m_dirty[idx] = 1'b1;
    end
    exp_hits = exp_hits + 32'd1;
  endtask

  // One memory transaction; the ack arrives in request cycle number 'lat'
  task automatic mem_phase(input bit is_wb, input logic [31:0] exp_addr,
                           input logic [127:0] exp_wdata, input int lat,
                           input logic req_held, input logic [127:0] fill);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      cpu_req_i   = req_held;
      mem_ack_i   = (k == lat);
      mem_rdata_i = (k == lat) ? fill : rand_line();
      #1;
      check(is_wb ? "wb_stall"   : "rf_stall",   cpu_stall_o, 1'b1);
      check(is_wb ? "wb_mem_req" : "rf_mem_req", mem_req_o,   1'b1);
      check(is_wb ? "wb_mem_we"  : "rf_mem_we",  mem_we_o,    is_wb);
      check(is_wb ? "wb_addr"    : "rf_addr",    mem_addr_o,  exp_addr);
      if (is_wb) check("wb_wdata", mem_wdata_o, exp_wdata);
      @(posedge clk);
    end
  endtask

  // Complete CPU access, including any miss handling. With flush set,
  // cpu_req_i drops while the miss is in flight.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int wb_lat, input int rf_lat, input bit flush);
    logic [3:0]   idx;
    logic [23:0]  tag;
    logic [31:0]  old_addr;
    logic [127:0] fill;
    idx = addr[7:4];
    tag = addr[31:8];
    if (m_valid[idx] && m_tag[idx] == tag) begin
      hit_cycle(we, addr, wdata);
    end else begin
      @(negedge clk);
      cpu_req_i   = 1'b1;
      cpu_we_i    = we;
      cpu_addr_i  = addr;
      cpu_wdata_i = wdata;
      mem_ack_i   = 1'($urandom_range(0, 1));
      #1;
      check("miss_stall",   cpu_stall_o, 1'b1);
      check("miss_mem_req", mem_req_o,   1'b0);
      @(posedge clk);
      exp_misses = exp_misses + 32'd1;
      if (m_valid[idx] && m_dirty[idx]) begin
        old_addr = {m_tag[idx], idx, 4'b0};
        mem_phase(1'b1, old_addr, m_data[idx], wb_lat, !flush, rand_line());
        bmem[old_addr[31:4]] = m_data[idx];
      end
      fill = mem_line({tag, idx});
      mem_phase(1'b0, {tag, idx, 4'b0}, 128'd0, rf_lat, !flush, fill);
      m_data[idx]  = fill;
      m_tag[idx]   = tag;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      if (flush) idle_cycle(1'b0);
      else       hit_cycle(we, addr, wdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] tag_pool [4];
    logic [31:0] a;
    tag_pool[0] = 24'h000000;
    tag_pool[1] = 24'h000001;
    tag_pool[2] = 24'hABCDE0;
    tag_pool[3] = 24'hFFFFFF;

    rst_i       = 1'b0;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'd0;
    cpu_wdata_i = 32'd0;
    mem_rdata_i = 128'd0;
    mem_ack_i   = 1'b0;
    model_reset();

    // Reset state
    #1;
    check("rst_stall",   cpu_stall_o, 1'b0);
    check("rst_mem_req", mem_req_o,   1'b0);
    check("rst_mem_we",  mem_we_o,    1'b0);
    check_counters("rst");
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    idle_cycle(1'b1);

    // 1. Cold load miss, refill {D,C,B,A} acked after 3 cycles
    bmem[28'h0000001] = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    access(1'b0, 32'h0000_0010, 32'd0, 0, 3, 1'b0);
    // 2. Load hit on word 1
    access(1'b0, 32'h0000_0014, 32'd0, 0, 0, 1'b0);
    // 3. Store hit, then load it back
    access(1'b1, 32'h0000_0018, 32'hDEAD_BEEF, 0, 0, 1'b0);
    access(1'b0, 32'h0000_0018, 32'd0, 0, 0, 1'b0);
    // 4. Conflict miss on the dirty line: write-back then refill
    access(1'b0, 32'h0000_0110, 32'd0, 2, 1, 1'b0);
    check("s4_wb_line", bmem[28'h0000001],
          {32'hDDDD_0003, 32'hDEAD_BEEF, 32'hBBBB_0001, 32'hAAAA_0000});
    check("s6_hit_cnt",  hit_cnt_o,  STATS_EN ? 32'd5 : 32'd0);
    check("s6_miss_cnt", miss_cnt_o, STATS_EN ? 32'd2 : 32'd0);
    check_counters("s4");
    idle_cycle(1'b0);

    // 5. Reset asserted during ALLOCATE
    @(negedge clk);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0010;
    mem_ack_i  = 1'b0;
    #1;
    check("s5_miss_stall", cpu_stall_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("s5_alloc_req", mem_req_o, 1'b1);
    rst_i     = 1'b0;
    cpu_req_i = 1'b0;
    #1;
    check("s5_rst_req",   mem_req_o,   1'b0);
    check("s5_rst_stall", cpu_stall_o, 1'b0);
    model_reset();
    @(negedge clk);
    rst_i = 1'b1;
    idle_cycle(1'b0);
    access(1'b0, 32'h0000_0010, 32'd0, 0, 2, 1'b0);
    check_counters("s5");

    // Randomized traffic, including occasional flushes mid-miss
    for (int n = 0; n < 300; n++) begin
      a = {tag_pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
    end
    idle_cycle(1'b0);
    check_counters("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
